output_gain_limiter: RTL

//  - Last processing stage of the filter chain. Consumes the final filter output
//    (data_in/sample_trig from the low-pass stage's data_out/filter_end) and produces
//    the sample written to both codec channels.
//  - Applies a ramped, zipper-free output gain with round-to-nearest and saturation.
//  - Reports clipping through a held indicator, suitable for driving an LED.

---
 rtl/output_gain_limiter_pkg.sv | 23 ++
 rtl/output_gain_limiter_sat_round.sv | 40 ++++
 rtl/output_gain_limiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/output_gain_limiter_pkg.sv
// Shared definitions for the output gain stage and later stages that reuse
// sat_round: sample/gain widths, saturation limits, ramp/hold defaults and
// the sequencing FSM encoding.
package output_gain_limiter_pkg;

    localparam int SAMPLE_W     = 24;
    localparam int GAIN_W       = 16;
    localparam int GAIN_FRAC    = 14;
    localparam int GAIN_UNITY   = 16384;
    localparam int GAIN_STEP    = 64;
    localparam int HOLD_SAMPLES = 4800;

    localparam logic [SAMPLE_W-1:0] SAT_MAX = 24'h7FFFFF;
    localparam logic [SAMPLE_W-1:0] SAT_MIN = 24'h800000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAP  = 2'd1,
        ST_MUL  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/output_gain_limiter_sat_round.sv
// sat_round: rounds a signed Q(FRAC) product to N bits (round half up) and
// saturates to the N-bit signed range.
//   prod   in   N+G+1  signed product of sample and unsigned gain
//   value  out  N      rounded, saturated sample
//   sat    out  1      value was clamped
module sat_round
    import output_gain_limiter_pkg::*;
#(
    parameter int N    = SAMPLE_W,
    parameter int G    = GAIN_W,
    parameter int FRAC = GAIN_FRAC
) (
    input  logic signed [N+G:0] prod,
    output logic        [N-1:0] value,
    output logic                sat
);

    localparam int PW = N + G + 1;

    localparam logic signed [PW-1:0] HALF  = {{(PW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [PW-1:0] R_MAX = {{(PW-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [PW-1:0] R_MIN = {{(PW-N+1){1'b1}}, {(N-1){1'b0}}};

    logic signed [PW-1:0] rounded;

    always_comb begin
        // The product never uses the top bit, so adding HALF cannot overflow.
        rounded = (prod + HALF) >>> FRAC;
        sat     = 1'b0;
        value   = rounded[N-1:0];
        if (rounded > R_MAX) begin
            value = {1'b0, {(N-1){1'b1}}};
            sat   = 1'b1;
        end else if (rounded < R_MIN) begin
            value = {1'b1, {(N-1){1'b0}}};
            sat   = 1'b1;
        end
    end

endmodule

// File: rtl/output_gain_limiter.sv
// output_gain_limiter: final stage of the filter chain. Applies a ramped
// (zipper-free) Q2.14 gain with rounding and saturation, and drives a held
// clip indicator.
//   clk          system clock
//   reset_n      async active-low reset
//   sample_trig  one-cycle pulse, data_in valid
//   data_in      signed input sample
//   gain_target  requested gain, Q2.14, sampled on acceptance
//   bypass       pass data_in through with the same latency
//   data_out     signed output sample, held between updates
//   filter_end   one-cycle pulse, data_out updated
//   clip         held saturation indicator
//   gain_cur     gain currently applied
//
// state | meaning
// IDLE  | waiting for sample_trig; captures sample, bypass, target
// CAP   | step gain_cur toward the captured target
// MUL   | register sample * gain_cur
// OUT   | round/saturate, update data_out, clip hold, pulse filter_end
module output_gain_limiter
    import output_gain_limiter_pkg::*;
#(
    parameter int N    = SAMPLE_W,
    parameter int G    = GAIN_W,
    parameter int FRAC = GAIN_FRAC,
    parameter int STEP = GAIN_STEP,
    parameter int HOLD = HOLD_SAMPLES
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         sample_trig,
    input  logic [N-1:0] data_in,
    input  logic [G-1:0] gain_target,
    input  logic         bypass,
    output logic [N-1:0] data_out,
    output logic         filter_end,
    output logic         clip,
    output logic [G-1:0] gain_cur
);

    localparam int PW = N + G + 1;
    localparam int HW = $clog2(HOLD + 1);
    localparam logic [G-1:0]  STEP_G = G'(STEP);
    localparam logic [HW-1:0] HOLD_V = HW'(HOLD);

    state_t state_q, state_d;

    logic [N-1:0]          data_q;
    logic                  byp_q;
    logic [G-1:0]          tgt_q;
    logic signed [PW-1:0]  prod_q;
    logic [HW-1:0]         hold_q;
    logic [G-1:0]          gain_d;
    logic [N-1:0]          rnd_val;
    logic                  rnd_sat;
    logic [N-1:0]          out_val;
    logic                  out_sat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (sample_trig) state_d = ST_CAP;
            ST_CAP:  state_d = ST_MUL;
            ST_MUL:  state_d = ST_OUT;
            ST_OUT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Slew-limited step toward the target captured with this sample.
    always_comb begin
        gain_d = gain_cur;
        if (tgt_q > gain_cur) begin
            if ((tgt_q - gain_cur) > STEP_G) gain_d = gain_cur + STEP_G;
            else                             gain_d = tgt_q;
        end else if (tgt_q < gain_cur) begin
            if ((gain_cur - tgt_q) > STEP_G) gain_d = gain_cur - STEP_G;
            else                             gain_d = tgt_q;
        end
    end

    sat_round #(.N(N), .G(G), .FRAC(FRAC)) u_sat_round (
        .prod  (prod_q),
        .value (rnd_val),
        .sat   (rnd_sat)
    );

    assign out_val = byp_q ? data_q : rnd_val;
    assign out_sat = !byp_q && rnd_sat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= '0;
            byp_q      <= 1'b0;
            tgt_q      <= '0;
            prod_q     <= '0;
            hold_q     <= '0;
            gain_cur   <= '0;
            data_out   <= '0;
            filter_end <= 1'b0;
            clip       <= 1'b0;
        end else begin
            filter_end <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sample_trig) begin
                        data_q <= data_in;
                        byp_q  <= bypass;
                        tgt_q  <= gain_target;
                    end
                end
                ST_CAP: gain_cur <= gain_d;
                ST_MUL: prod_q <= PW'($signed(data_q)) * PW'($signed({1'b0, gain_cur}));
                ST_OUT: begin
                    data_out   <= out_val;
                    filter_end <= 1'b1;
                    if (out_sat) begin
                        hold_q <= HOLD_V;
                        clip   <= 1'b1;
                    end else if (hold_q != '0) begin
                        hold_q <= hold_q - 1'b1;
                        if (hold_q == HW'(1)) clip <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
